// File: rtl/counter_sched_pkg.sv
// Shared defaults and sizing helpers for the round-robin counter scheduler.
package counter_sched_pkg;

  localparam int CNT_WIDTH   = 4;
  localparam int CNT_NUM_REQ = 4;

  // Pointer width; a 1-bit floor keeps a 2-requester bank legal.
  function automatic int calc_ptr_w(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Combinational round-robin arbiter: first request at or above ptr wins,
// wrapping to index 0 when nothing at or above ptr is requesting.
module rr_arbiter_onehot #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid,
  output logic [PTR_W-1:0]   idx
);

  // Two passes over the vector avoid a modulo: upper segment first, then wrap.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid && req[i] && (PTR_W'(i) >= ptr)) begin
        valid    = 1'b1;
        grant[i] = 1'b1;
        idx      = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid && req[i]) begin
        valid    = 1'b1;
        grant[i] = 1'b1;
        idx      = PTR_W'(i);
      end
    end
  end

endmodule

// File: rtl/counter_rr_scheduler.sv
// Bank of counters sharing one incrementer; round-robin grants one increment
// per cycle, and per-counter clears act directly without arbitration.
module counter_rr_scheduler
  import counter_sched_pkg::*;
#(
  parameter int NUM_REQ = CNT_NUM_REQ,
  parameter int WIDTH   = CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_REQ-1:0]       inc_req,
  input  logic [NUM_REQ-1:0]       clr_req,
  output logic [NUM_REQ-1:0]       ack,
  output logic [NUM_REQ-1:0]       wrap,
  output logic                     grant_valid,
  output logic [NUM_REQ*WIDTH-1:0] q
);

  localparam int PTR_W = calc_ptr_w(NUM_REQ);

  logic [WIDTH-1:0]   cnt [NUM_REQ];
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   next_ptr;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic               grant_hit;
  logic [WIDTH-1:0]   sel_cnt;
  logic [WIDTH-1:0]   inc_cnt;

  // Masking with the current ack stops a still-held request being counted twice.
  assign eligible = inc_req & ~clr_req & ~ack & {NUM_REQ{en}};

  rr_arbiter_onehot #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req   (eligible),
    .ptr   (ptr),
    .grant (grant),
    .valid (grant_hit),
    .idx   (win)
  );

  always_comb begin
    sel_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_cnt = cnt[i];
    end
    inc_cnt  = sel_cnt + WIDTH'(1);
    next_ptr = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ack         <= '0;
      wrap        <= '0;
      grant_valid <= 1'b0;
      ptr         <= '0;
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else begin
      ack         <= grant;
      wrap        <= grant & {NUM_REQ{&sel_cnt}};
      grant_valid <= grant_hit;
      if (grant_hit) ptr <= next_ptr;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (clr_req[i])    cnt[i] <= '0;
        else if (grant[i]) cnt[i] <= inc_cnt;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_q
    assign q[g*WIDTH +: WIDTH] = cnt[g];
  end

endmodule

// File: tb/tb_counter_rr_scheduler.sv
// Directed, table-driven bench for counter_rr_scheduler (NUM_REQ=4, WIDTH=4).
module tb_counter_rr_scheduler;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  inc_req;
  logic [3:0]  clr_req;
  logic [3:0]  ack;
  logic [3:0]  wrap;
  logic        grant_valid;
  logic [15:0] q;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  inc;
    logic [3:0]  clr;
    logic [3:0]  ack;
    logic [3:0]  wrap;
    logic        gv;
    logic [15:0] q;
  } vec_t;

  vec_t vecs [37];

  counter_rr_scheduler #(.NUM_REQ(4), .WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .inc_req     (inc_req),
    .clr_req     (clr_req),
    .ack         (ack),
    .wrap        (wrap),
    .grant_valid (grant_valid),
    .q           (q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic e,
                               input logic [3:0] inc, input logic [3:0] clr);
    rst     = r;
    en      = e;
    inc_req = inc;
    clr_req = clr;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] e_ack,
                             input logic [3:0] e_wrap, input logic e_gv,
                             input logic [15:0] e_q);
    tests_run++;
    if (ack !== e_ack) begin
      tests_failed++;
      $display("[TB] FAIL %s ack: got %b, expected %b", name, ack, e_ack);
    end
    tests_run++;
    if (wrap !== e_wrap) begin
      tests_failed++;
      $display("[TB] FAIL %s wrap: got %b, expected %b", name, wrap, e_wrap);
    end
    tests_run++;
    if (grant_valid !== e_gv) begin
      tests_failed++;
      $display("[TB] FAIL %s grant_valid: got %b, expected %b", name, grant_valid, e_gv);
    end
    tests_run++;
    if (q !== e_q) begin
      tests_failed++;
      $display("[TB] FAIL %s q: got %h, expected %h", name, q, e_q);
    end
  endtask

  task automatic runVectors(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].inc, vecs[i].clr);
      tick();
      checkOutput($sformatf("vec%0d", i), vecs[i].ack, vecs[i].wrap, vecs[i].gv, vecs[i].q);
    end
  endtask

  // Raise one request, wait (bounded) for its ack, then drop it for a cycle.
  task automatic incOnce(input int idx);
    logic [3:0] bit_mask;
    bit         seen;
    bit_mask = 4'b0001 << idx;
    seen     = 1'b0;
    applyStimulus(1'b1, 1'b1, bit_mask, 4'b0000);
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if ((ack & bit_mask) != 4'b0000) seen = 1'b1;
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("[TB] FAIL incOnce%0d ack: got none, expected ack within 10 cycles", idx);
    end
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000);
    tick();
  endtask

  function automatic vec_t mk(input logic r, input logic e, input logic [3:0] inc,
                              input logic [3:0] clr, input logic [3:0] a,
                              input logic [3:0] w, input logic gv, input logic [15:0] qq);
    vec_t v;
    v.rst = r; v.en = e; v.inc = inc; v.clr = clr;
    v.ack = a; v.wrap = w; v.gv = gv; v.q = qq;
    return v;
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // Reset, then fairness with all four requesting.
    vecs[0]  = mk(0, 1, 4'hF, 4'h0, 4'h0, 4'h0, 0, 16'h0000);
    vecs[1]  = mk(0, 1, 4'hF, 4'h0, 4'h0, 4'h0, 0, 16'h0000);
    vecs[2]  = mk(1, 1, 4'hF, 4'h0, 4'h1, 4'h0, 1, 16'h0001);
    vecs[3]  = mk(1, 1, 4'hF, 4'h0, 4'h2, 4'h0, 1, 16'h0011);
    vecs[4]  = mk(1, 1, 4'hF, 4'h0, 4'h4, 4'h0, 1, 16'h0111);
    vecs[5]  = mk(1, 1, 4'hF, 4'h0, 4'h8, 4'h0, 1, 16'h1111);
    vecs[6]  = mk(1, 1, 4'hF, 4'h0, 4'h1, 4'h0, 1, 16'h1112);
    vecs[7]  = mk(1, 1, 4'hF, 4'h0, 4'h2, 4'h0, 1, 16'h1122);
    vecs[8]  = mk(1, 1, 4'hF, 4'h0, 4'h4, 4'h0, 1, 16'h1222);
    vecs[9]  = mk(1, 1, 4'hF, 4'h0, 4'h8, 4'h0, 1, 16'h2222);
    vecs[10] = mk(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 16'h2222);
    vecs[11] = mk(1, 1, 4'h0, 4'hF, 4'h0, 4'h0, 0, 16'h0000);
    // Single requester 2: one increment every other cycle.
    vecs[12] = mk(1, 1, 4'h4, 4'h0, 4'h4, 4'h0, 1, 16'h0100);
    vecs[13] = mk(1, 1, 4'h4, 4'h0, 4'h0, 4'h0, 0, 16'h0100);
    vecs[14] = mk(1, 1, 4'h4, 4'h0, 4'h4, 4'h0, 1, 16'h0200);
    vecs[15] = mk(1, 1, 4'h4, 4'h0, 4'h0, 4'h0, 0, 16'h0200);
    vecs[16] = mk(1, 1, 4'h4, 4'h0, 4'h4, 4'h0, 1, 16'h0300);
    vecs[17] = mk(1, 1, 4'h4, 4'h0, 4'h0, 4'h0, 0, 16'h0300);
    vecs[18] = mk(1, 1, 4'h4, 4'h0, 4'h4, 4'h0, 1, 16'h0400);
    vecs[19] = mk(1, 1, 4'h4, 4'h0, 4'h0, 4'h0, 0, 16'h0400);
    vecs[20] = mk(1, 1, 4'h4, 4'h0, 4'h4, 4'h0, 1, 16'h0500);
    vecs[21] = mk(1, 1, 4'h4, 4'h0, 4'h0, 4'h0, 0, 16'h0500);
    vecs[22] = mk(1, 1, 4'h0, 4'hF, 4'h0, 4'h0, 0, 16'h0000);
    // Clear collides with pending request 0 while 3 is granted.
    vecs[23] = mk(1, 1, 4'h9, 4'h1, 4'h8, 4'h0, 1, 16'h8000);
    vecs[24] = mk(1, 1, 4'h1, 4'h0, 4'h1, 4'h0, 1, 16'h8001);
    vecs[25] = mk(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 16'h8001);
    // Enable gating; clear still acts while en is low.
    vecs[26] = mk(1, 0, 4'h6, 4'h0, 4'h0, 4'h0, 0, 16'h8012);
    vecs[27] = mk(1, 0, 4'h6, 4'h0, 4'h0, 4'h0, 0, 16'h8012);
    vecs[28] = mk(1, 0, 4'h6, 4'h2, 4'h0, 4'h0, 0, 16'h8002);
    vecs[29] = mk(1, 0, 4'h6, 4'h0, 4'h0, 4'h0, 0, 16'h8002);
    vecs[30] = mk(1, 0, 4'h6, 4'h0, 4'h0, 4'h0, 0, 16'h8002);
    vecs[31] = mk(1, 1, 4'h6, 4'h0, 4'h2, 4'h0, 1, 16'h8012);
    vecs[32] = mk(1, 1, 4'h4, 4'h0, 4'h4, 4'h0, 1, 16'h8112);
    vecs[33] = mk(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 16'h8112);
    // Mid-operation reset drops counts and restarts the pointer at 0.
    vecs[34] = mk(1, 1, 4'hF, 4'h0, 4'h8, 4'h0, 1, 16'h9112);
    vecs[35] = mk(0, 1, 4'hF, 4'h0, 4'h0, 4'h0, 0, 16'h0000);
    vecs[36] = mk(1, 1, 4'hF, 4'h0, 4'h1, 4'h0, 1, 16'h0001);

    applyStimulus(1'b0, 1'b1, 4'hF, 4'h0);
    runVectors(0, 22);

    // Requester 1 alone from ptr=3: grants on odd cycles, 16th grant wraps.
    applyStimulus(1'b1, 1'b1, 4'h2, 4'h0);
    for (int c = 1; c <= 31; c++) begin
      int          grants;
      logic [3:0]  q1;
      logic [3:0]  e_ack;
      logic [3:0]  e_wrap;
      grants = (c + 1) / 2;
      q1     = 4'(grants % 16);
      e_ack  = (c % 2 == 1) ? 4'h2 : 4'h0;
      e_wrap = (c == 31) ? 4'h2 : 4'h0;
      tick();
      checkOutput($sformatf("wrap_c%0d", c), e_ack, e_wrap, (c % 2 == 1), {8'h00, q1, 4'h0});
    end
    applyStimulus(1'b1, 1'b1, 4'h0, 4'h0);
    tick();
    checkOutput("wrap_after", 4'h0, 4'h0, 1'b0, 16'h0000);

    // Build q0=3, q3=7 with the pointer resting at 0.
    for (int k = 0; k < 3; k++) incOnce(0);
    for (int k = 0; k < 7; k++) incOnce(3);
    checkOutput("collision_setup", 4'h0, 4'h0, 1'b0, 16'h7003);
    runVectors(23, 25);

    incOnce(1);
    incOnce(0);
    checkOutput("enable_setup", 4'h0, 4'h0, 1'b0, 16'h8012);
    runVectors(26, 36);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/counter_rr_scheduler.md
Name: counter_rr_scheduler

Overview:
- Owns a bank of NUM_REQ WIDTH-bit count registers that share a single incrementer.
- Round-robin arbitration grants at most one increment per cycle.
- A requester raises an increment request and holds it until it receives a one-cycle acknowledge.
- Per-counter synchronous clears bypass arbitration. The block is a single-clock replacement for independently clocked free-running counters.

Parameters:
- NUM_REQ, 4, number of requesters/counters (2..8).
- WIDTH, 4, bits per counter.

Ports:
- clk  input  1  sole clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset).
- en  input  1  global enable; 0 = no new grants.
- inc_req  input  NUM_REQ  per-requester increment request, level, held until ack.
- clr_req  input  NUM_REQ  per-counter clear, single-cycle or level.
- ack  output  NUM_REQ  one-hot (or zero) pulse: increment for that requester completed.
- wrap  output  NUM_REQ  pulse with ack when that counter rolled from all-ones to zero.
- grant_valid  output  1  registered: an increment was performed on the previous edge (= |ack).
- q  output  NUM_REQ*WIDTH  counter values; counter i at bits [i*WIDTH +: WIDTH].

Behaviour:
- Reset (rst=0 at posedge):
  - All q=0, ack=0, wrap=0, grant_valid=0, round-robin pointer ptr=0.
  - Reset overrides clr_req/inc_req.
- Eligibility in cycle N: eligible[i] = inc_req[i] & ~clr_req[i] & ~ack[i] & en.
  - ack[i] high in cycle N excludes requester i, so a requester that has not yet dropped inc_req is not double-counted.
  - Consequence: max single-requester rate is one increment per 2 cycles.
- Arbitration (combinational, cycle N):
  - Search eligible from index ptr upward, wrapping modulo NUM_REQ; the first hit is winner w.
  - No eligible requester means no grant, and ptr holds.
- Update at posedge ending cycle N:
  - q[w] <= q[w]+1, modulo 2^WIDTH.
  - ack <= onehot(w), grant_valid <= 1.
  - wrap[w] <= 1 iff old q[w] was all-ones.
  - ptr <= (w+1) mod NUM_REQ.
  - Latency is 1 cycle: ack and the new q value become visible together in cycle N+1.
- No grant: ack, wrap and grant_valid all 0 next cycle.
- Clear: clr_req[i]=1 at posedge sets q[i] <= 0 regardless of en.
  - No ack, no wrap.
  - Several clears in the same cycle are all applied.
  - A clear and a grant to different counters in the same cycle are both applied.
  - A requester with clr_req high is not eligible; its inc_req stays pending and is serviced later.
- en=0: no grants and ptr frozen. Pending requests are serviced once en returns.
- Requester protocol:
  - inc_req must stay high until ack is seen, then drop in the cycle after ack.
  - A request dropped before ack is legal: it is simply not counted.
- Mid-operation reset: any in-flight ack is suppressed and all counts are lost.

Decomposition:
- Package counter_sched_pkg holds:
  - defaults CNT_WIDTH=4 and CNT_NUM_REQ=4;
  - PTR_W = clog2(NUM_REQ) helper function.
- Sub-module rr_arbiter_onehot (NUM_REQ):
  - inputs: request vector and ptr;
  - outputs: one-hot grant, valid, winner index.
  - Purely combinational.
- The top level holds the counter bank, ptr, ack/wrap registers and the increment mux.

Test Plan:
- Reset: hold rst=0 for 2 cycles with inc_req=4'b1111 -> q=0, ack=0, wrap=0, grant_valid=0. After release, first ack=4'b0001.
- Fairness: all four inc_req held continuously (re-raised after ack) for 8 grants -> ack order 0,1,2,3,0,1,2,3; each q=2; one grant per cycle.
- Single requester: only inc_req[2] held continuously for 10 cycles -> ack[2] on alternate cycles; q[2]=5 after 10 cycles; other q=0.
- Wrap: preset q[1]=15 via 15 increments, then 1 more -> q[1]=0; wrap=4'b0010 and ack=4'b0010 in the same cycle; no wrap on any other increment.
- Clear collision: q[0]=3, q[3]=7, ptr=0, clr_req=4'b0001 with inc_req=4'b1001 -> next cycle q[0]=0, q[3]=8, ack=4'b1000. The following cycle requester 0 is granted (q[0]=1).
- Enable gating: en=0 with inc_req=4'b0110 for 5 cycles -> no ack, q unchanged, clr_req[1] still clears. On en=1, grants go to 1 then 2.
